// File: rtl/clip_sequencer_pkg.sv
// clip_seq_pkg: shared types and widths for the two-clip record/playback sequencer
package clip_seq_pkg;
  localparam int NUM_CLIPS = 2;
  localparam int DEF_WORD_LENGTH = 16;
  localparam int DEF_ADDR_WIDTH = 17;
  localparam int DEF_DEPTH = 131072;
  typedef enum logic [2:0] {IDLE, REC, REC_WRITE, PLAY_LOAD, PLAY_RUN} state_t;
  typedef logic clip_t;
  typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
  typedef logic [DEF_ADDR_WIDTH:0] len_t;
endpackage

// File: rtl/clip_sequencer_if.sv
// clip_sequencer_if: commands, (de)serializer handshake and BRAM port of the sequencer
interface clip_sequencer_if
  import clip_seq_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
  logic play_command, record_command;
  clip_t play_clip_select, record_clip_select;
  logic deserializer_done, deserializer_enable;
  logic [WORD_LENGTH-1:0] deserializer_data;
  logic serializer_done, serializer_enable;
  logic [WORD_LENGTH-1:0] serializer_data;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic memory_write, memory_bank;
  logic [WORD_LENGTH-1:0] memory_write_data, memory_read_data;
  logic [3:0] play_clip, record_clip;
  logic busy;
  modport master (
    input play_command, record_command, play_clip_select, record_clip_select,
    input deserializer_done, deserializer_data, serializer_done, memory_read_data,
    output deserializer_enable, serializer_enable, serializer_data, memory_address,
    output memory_write, memory_write_data, memory_bank, play_clip, record_clip, busy
  );
  modport slave (
    output play_command, record_command, play_clip_select, record_clip_select,
    output deserializer_done, deserializer_data, serializer_done, memory_read_data,
    input deserializer_enable, serializer_enable, serializer_data, memory_address,
    input memory_write, memory_write_data, memory_bank, play_clip, record_clip, busy
  );
endinterface

// File: rtl/clip_sequencer_command_edge_detect.sv
// command_edge_detect: registers a command level and flags its rising and falling edges
module command_edge_detect (
  input logic clock_i,
  input logic reset_i,
  input logic level,
  output logic rise,
  output logic fall
);
  logic prev;
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) prev <= 1'b0;
    else prev <= level;
  assign rise = level & ~prev;
  assign fall = ~level & prev;
endmodule

// File: rtl/clip_sequencer.sv
// clip_sequencer: moves samples deserializer -> BRAM bank on record and BRAM bank -> serializer on play
module clip_sequencer
  import clip_seq_pkg::*;
#(
  parameter int WORD_LENGTH = DEF_WORD_LENGTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int READ_LATENCY = 1
) (
  input logic clock_i,
  input logic reset_i,
  clip_sequencer_if.master bus
);
  localparam int CW = $clog2(READ_LATENCY + 2);
  state_t state, state_n;
  clip_t bank, bank_n, play_clip, record_clip;
  logic [ADDR_WIDTH-1:0] addr, addr_n;
  logic [ADDR_WIDTH:0] len [NUM_CLIPS];
  logic [ADDR_WIDTH:0] commit_len;
  logic [WORD_LENGTH-1:0] wdata, wdata_n, sdata, sdata_n;
  logic [CW-1:0] cnt, cnt_n;
  logic ser_en, ser_en_n, stop_pend, stop_pend_n, commit, stop;
  logic play_rise, play_fall, rec_rise, rec_fall;

  command_edge_detect u_play (.clock_i, .reset_i, .level(bus.play_command), .rise(play_rise), .fall(play_fall));
  command_edge_detect u_rec (.clock_i, .reset_i, .level(bus.record_command), .rise(rec_rise), .fall(rec_fall));

  always_comb begin
    state_n = state;
    addr_n = addr;
    bank_n = bank;
    wdata_n = wdata;
    sdata_n = sdata;
    cnt_n = cnt;
    ser_en_n = ser_en;
    stop_pend_n = 1'b0;
    commit = 1'b0;
    commit_len = '0;
    // a stop that lands while a sample is in flight is held until the write completes
    stop = rec_fall | stop_pend;
    case (state)
      IDLE:
        if (rec_rise) begin
          bank_n = bus.record_clip_select;
          state_n = REC;
        end else if (play_rise & ~play_fall) begin
          bank_n = bus.play_clip_select;
          cnt_n = '0;
          state_n = len[bus.play_clip_select] != '0 ? PLAY_LOAD : IDLE;
        end
      REC:
        if (bus.deserializer_done) begin
          wdata_n = bus.deserializer_data;
          stop_pend_n = stop;
          state_n = REC_WRITE;
        end else if (stop) begin
          commit = 1'b1;
          commit_len = {1'b0, addr};
          addr_n = '0;
          state_n = IDLE;
        end
      REC_WRITE:
        if (addr == ADDR_WIDTH'(DEPTH - 1)) begin
          commit = 1'b1;
          commit_len = (ADDR_WIDTH + 1)'(DEPTH);
          addr_n = '0;
          state_n = IDLE;
        end else begin
          addr_n = addr + 1'b1;
          stop_pend_n = stop;
          state_n = REC;
        end
      PLAY_LOAD:
        if (cnt == CW'(READ_LATENCY)) begin
          sdata_n = bus.memory_read_data;
          ser_en_n = 1'b1;
          state_n = PLAY_RUN;
        end else cnt_n = cnt + 1'b1;
      PLAY_RUN:
        if (bus.serializer_done) begin
          if ({1'b0, addr} + 1'b1 == len[bank]) begin
            ser_en_n = 1'b0;
            addr_n = '0;
            state_n = IDLE;
          end else begin
            addr_n = addr + 1'b1;
            cnt_n = '0;
            state_n = PLAY_LOAD;
          end
        end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) begin
      state <= IDLE;
      addr <= '0;
      bank <= '0;
      wdata <= '0;
      sdata <= '0;
      cnt <= '0;
      ser_en <= 1'b0;
      stop_pend <= 1'b0;
      play_clip <= '0;
      record_clip <= '0;
      len <= '{default: '0};
    end else begin
      state <= state_n;
      addr <= addr_n;
      bank <= bank_n;
      wdata <= wdata_n;
      sdata <= sdata_n;
      cnt <= cnt_n;
      ser_en <= ser_en_n;
      stop_pend <= stop_pend_n;
      if (commit) len[bank] <= commit_len;
      if (state == IDLE) begin
        play_clip <= bus.play_clip_select;
        record_clip <= bus.record_clip_select;
      end
    end

  assign bus.deserializer_enable = state == REC || state == REC_WRITE;
  assign bus.memory_write = state == REC_WRITE;
  assign bus.memory_write_data = wdata;
  assign bus.memory_address = addr;
  assign bus.memory_bank = bank;
  assign bus.serializer_enable = ser_en;
  assign bus.serializer_data = sdata;
  assign bus.play_clip = {3'b0, play_clip};
  assign bus.record_clip = {3'b0, record_clip};
  assign bus.busy = state != IDLE;
endmodule

// File: tb/tb_clip_sequencer.sv
// tb_clip_sequencer: directed + randomized record/playback against a clip-content reference model
module tb_clip_sequencer;
  localparam int WL = 16, AW = 17, D = 8, RL = 1;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_err = 0, n_chk = 0, ser_rises = 0;
  logic prev_en = 1'b0;
  logic [WL-1:0] bram [2][D];
  logic [WL-1:0] ref_clip [2][$];
  typedef struct packed {logic bank; logic [AW-1:0] addr; logic [WL-1:0] data;} wr_t;
  wr_t wr_log [$];

  always #5 clk = ~clk;

  clip_sequencer_if #(.WORD_LENGTH(WL), .ADDR_WIDTH(AW)) bus ();
  clip_sequencer #(.WORD_LENGTH(WL), .ADDR_WIDTH(AW), .DEPTH(D), .READ_LATENCY(RL)) dut (
    .clock_i(clk), .reset_i(rst_n), .bus(bus));

  always @(posedge clk) begin
    if (bus.memory_write) bram[bus.memory_bank][bus.memory_address[2:0]] <= bus.memory_write_data;
    bus.memory_read_data <= bram[bus.memory_bank][bus.memory_address[2:0]];
  end

  always @(negedge clk) begin
    if (bus.memory_write) wr_log.push_back({bus.memory_bank, bus.memory_address, bus.memory_write_data});
    if (bus.serializer_enable && !prev_en) ser_rises++;
    prev_en = bus.serializer_enable;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic record(input logic c, input int n, input bit directed, input int mode, input bit with_play);
    logic [WL-1:0] d[$];
    int exp_len = n < D ? n : D;
    int rises = ser_rises;
    wr_log.delete();
    @(negedge clk);
    bus.record_clip_select = c;
    bus.record_command = 1'b1;
    if (with_play) begin
      bus.play_clip_select = ~c;
      bus.play_command = 1'b1;
    end
    @(negedge clk);
    check("rec_busy", bus.busy, 1);
    check("rec_bank", bus.memory_bank, c);
    check("rec_des_en", bus.deserializer_enable, 1);
    bus.record_clip_select = ~c;
    cycles(2);
    check("rec_led_frozen", bus.record_clip, {3'b0, c});
    for (int i = 0; i < n; i++) begin
      d.push_back(directed ? WL'((i + 1) * 'h11) : WL'($urandom));
      bus.deserializer_data = d[i];
      bus.deserializer_done = 1'b1;
      if (i == n - 1 && mode == 1) bus.record_command = 1'b0;
      @(negedge clk);
      bus.deserializer_done = 1'b0;
      if (i == n - 1 && mode == 2) bus.record_command = 1'b0;
      cycles(3);
    end
    bus.record_command = 1'b0;
    cycles(3);
    check("rec_end_busy", bus.busy, 0);
    check("rec_end_des_en", bus.deserializer_enable, 0);
    check("rec_write_count", wr_log.size(), exp_len);
    for (int i = 0; i < exp_len && i < wr_log.size(); i++) begin
      check("rec_write_addr", wr_log[i].addr, i);
      check("rec_write_data", wr_log[i].data, d[i]);
      check("rec_write_bank", wr_log[i].bank, c);
    end
    if (with_play) begin
      check("rec_play_ignored", ser_rises, rises);
      bus.play_command = 1'b0;
      cycles(2);
    end
    ref_clip[c].delete();
    for (int i = 0; i < exp_len; i++) ref_clip[c].push_back(d[i]);
  endtask

  task automatic play(input logic c, input int abort_at);
    logic [WL-1:0] e[$];
    int rises = ser_rises;
    int t = 0;
    e = ref_clip[c];
    @(negedge clk);
    bus.play_clip_select = c;
    bus.play_command = 1'b1;
    @(negedge clk);
    bus.play_command = 1'b0;
    if (e.size() == 0) begin
      cycles(4);
      check("empty_busy", bus.busy, 0);
      check("empty_no_enable", ser_rises, rises);
      check("empty_bank", bus.memory_bank, c);
      return;
    end
    while (!bus.serializer_enable && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("play_start", bus.serializer_enable, 1);
    for (int i = 0; i < e.size(); i++) begin
      check("play_data", bus.serializer_data, e[i]);
      check("play_addr", bus.memory_address, i);
      if (i == abort_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_ser_en", bus.serializer_enable, 0);
        check("abort_ser_data", bus.serializer_data, 0);
        check("abort_addr", bus.memory_address, 0);
        check("abort_bank", bus.memory_bank, 0);
        check("abort_wr", {bus.memory_write, bus.memory_write_data}, 0);
        check("abort_leds", {bus.play_clip, bus.record_clip}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ref_clip[0].delete();
        ref_clip[1].delete();
        return;
      end
      bus.serializer_done = 1'b1;
      @(negedge clk);
      bus.serializer_done = 1'b0;
      if (i == e.size() - 1) begin
        check("play_end_enable", bus.serializer_enable, 0);
        check("play_end_addr", bus.memory_address, 0);
        check("play_end_busy", bus.busy, 0);
      end else begin
        check("play_enable_held", bus.serializer_enable, 1);
        cycles(3);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.play_command = 1'b0;
    bus.record_command = 1'b0;
    bus.play_clip_select = 1'b0;
    bus.record_clip_select = 1'b0;
    bus.deserializer_done = 1'b0;
    bus.deserializer_data = '0;
    bus.serializer_done = 1'b0;
    cycles(2);
    check("reset_busy", bus.busy, 0);
    check("reset_enables", {bus.serializer_enable, bus.deserializer_enable, bus.memory_write}, 0);
    check("reset_addr", bus.memory_address, 0);
    check("reset_data", {bus.serializer_data, bus.memory_write_data}, 0);
    check("reset_leds", {bus.play_clip, bus.record_clip, 3'b0, bus.memory_bank}, 0);
    rst_n = 1'b1;
    bus.play_clip_select = 1'b1;
    cycles(2);
    check("idle_led_play", bus.play_clip, 4'b0001);
    check("idle_led_record", bus.record_clip, 4'b0000);
    bus.play_clip_select = 1'b0;
    record(1'b0, 5, 1'b1, 0, 1'b0);
    play(1'b0, -1);
    play(1'b1, -1);
    record(1'b1, 3, 1'b0, 0, 1'b1);
    play(1'b1, -1);
    record(1'b1, 10, 1'b0, 0, 1'b0);
    play(1'b1, -1);
    record(1'b0, 0, 1'b0, 0, 1'b0);
    play(1'b0, -1);
    for (int k = 0; k < 8; k++) begin
      record(1'($urandom_range(0, 1)), $urandom_range(0, 10), 1'b0, $urandom_range(0, 2), 1'b0);
      play(1'($urandom_range(0, 1)), -1);
    end
    record(1'b0, 6, 1'b0, 0, 1'b0);
    play(1'b0, 2);
    play(1'b0, -1);
    play(1'b1, -1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/clip_sequencer.md
Name: clip_sequencer

Overview:
Sequences record and playback for the two-clip audio recorder. Moves samples from the deserializer into the selected BRAM clip bank, and from the bank into the serializer. Owns the shared memory address, write strobe and bank select, and the per-clip recorded length. Sits between the synchronized user commands and the timer, serializer, deserializer and BRAM datapath.

Parameters:
WORD_LENGTH, 16, sample/word width in bits
ADDR_WIDTH, 17, BRAM address width
DEPTH, 131072, samples per clip bank (at most 2**ADDR_WIDTH)
READ_LATENCY, 1, BRAM clock cycles from address to valid douta

Ports:
clock_i  in  1  100 MHz system clock
reset_i  in  1  asynchronous, active-low reset
play_command_i  in  1  synchronized play level; rising edge starts playback
record_command_i  in  1  synchronized record level; rising edge starts recording, falling edge stops it
play_clip_select_i  in  1  synchronized clip choice for playback
record_clip_select_i  in  1  synchronized clip choice for recording
deserializer_done_i  in  1  1-cycle pulse: deserializer_data_i holds a new sample
deserializer_data_i  in  WORD_LENGTH  captured microphone sample
deserializer_enable_o  out  1  enables the deserializer
serializer_done_i  in  1  1-cycle pulse: serializer finished the current word
serializer_enable_o  out  1  enables the serializer
serializer_data_o  out  WORD_LENGTH  word for the serializer to play
memory_address_o  out  ADDR_WIDTH  BRAM address (shared by both banks)
memory_write_o  out  1  BRAM wea, 1-cycle strobe
memory_write_data_o  out  WORD_LENGTH  BRAM dina
memory_read_data_i  in  WORD_LENGTH  douta of the selected bank
memory_bank_o  out  1  active bank (0/1); drives the bank enables
play_clip_o  out  4  LED value for the play clip, {3'b0, clip}
record_clip_o  out  4  LED value for the record clip, {3'b0, clip}
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset (reset_i=0, async): state=IDLE; every output 0; both clip_length registers 0; edge-detect history 0.
- States: IDLE, REC, REC_WRITE, PLAY_LOAD, PLAY_RUN.
- IDLE:
  - Enables and write strobe are 0; address is 0.
  - play_clip_o and record_clip_o track the select inputs with a 1-cycle register delay.
  - A record rising edge latches record_clip_select_i into memory_bank_o and goes to REC. Record wins if both edges arrive in the same cycle.
  - Otherwise a play rising edge latches play_clip_select_i. If clip_length of that clip is 0, stay in IDLE; else go to PLAY_LOAD.
- Clip selects and LED outputs are frozen while busy_o=1. Command edges other than the record falling edge are ignored while busy.
- REC:
  - deserializer_enable_o=1.
  - On deserializer_done_i: register the sample into memory_write_data_o, go to REC_WRITE.
  - On a record falling edge with no pending sample: clip_length[bank] <= address, go to IDLE.
- REC_WRITE (one cycle):
  - memory_write_o=1 at the current address.
  - Next cycle address+1 and return to REC.
  - If the write was to address DEPTH-1: clip_length[bank] <= DEPTH, go to IDLE (full, auto-stop).
  - A falling edge that arrives during REC_WRITE takes effect in the following REC cycle; the pending sample is always written.
- Required: done pulses are at least 3 cycles apart (guaranteed at 1 MHz sampling). A pulse during REC_WRITE is dropped.
- PLAY_LOAD:
  - Address is driven and held for READ_LATENCY+1 cycles, then memory_read_data_i is captured into serializer_data_o and the state goes to PLAY_RUN.
  - serializer_enable_o rises on entry to the first PLAY_RUN and stays 1 through later PLAY_LOAD/PLAY_RUN cycles.
- PLAY_RUN:
  - On serializer_done_i: if address+1 == clip_length[bank], go to IDLE (enable drops the next cycle, address returns to 0).
  - Otherwise address+1 and go to PLAY_LOAD.
  - The serializer must not sample serializer_data_o earlier than READ_LATENCY+2 cycles after its done pulse.
- Width rules:
  - Address wraps are impossible: the address never exceeds DEPTH-1.
  - clip_length is ADDR_WIDTH+1 bits, so DEPTH is representable.
- Re-recording a clip overwrites it and replaces its length. Recording with zero samples sets the length to 0.
- Reset mid-operation aborts immediately with no partial length commit (lengths are cleared).

Decomposition:
- Package clip_seq_pkg holds:
  - state_t enum {IDLE, REC, REC_WRITE, PLAY_LOAD, PLAY_RUN}
  - clip_t (1-bit clip index)
  - NUM_CLIPS=2
  - the addr_t and len_t widths derived from ADDR_WIDTH
- One sub-module, command_edge_detect: registers a level and emits rise/fall pulses. It is instantiated for play and for record.

Test Plan:
- Reset, then record clip 0: raise record, give 5 done pulses with data 0x0011..0x0055, drop record → 5 wea strobes at addresses 0..4 with matching dina; clip_length[0]=5; busy_o=0.
- Play clip 0 after that → serializer_data_o sequence 0x0011..0x0055, 5 words, one per serializer_done_i; serializer_enable_o drops after the 5th done; address returns to 0.
- Play clip 1 when never recorded → stays in IDLE; serializer_enable_o never rises.
- Record and play rising edges in the same cycle → REC entered; play ignored for the whole recording.
- Record with DEPTH=8 override and record held for 10 pulses → 8 writes (addresses 0..7), auto-stop, clip_length=8; the remaining pulses are ignored.
- Assert reset_i=0 mid-playback at word 3 → all outputs 0 asynchronously; a following play of the same clip stays in IDLE (length cleared).
